// File: rtl/data_mem_lsu.sv
// Load/store unit with an embedded synchronous-read word memory. Misaligned
// accesses either span two consecutive words (wrapping at the top) or are rejected.
module data_mem_lsu #(
  parameter int ADDR_WIDTH     = 15,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam int NWORDS = 1 << WIDX_W;

  typedef enum logic {ST_ACCEPT = 1'b0, ST_SPLIT = 1'b1} state_e;

  function automatic logic [3:0] size_mask(input logic [2:0] op);
    case (op[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic op_illegal(input logic we, input logic [2:0] op);
    if (we) op_illegal = !(op == 3'b000 || op == 3'b001 || op == 3'b010);
    else    op_illegal = (op == 3'b011 || op == 3'b110 || op == 3'b111);
  endfunction

  // Pick the 32-bit lane starting at the byte offset, then size and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] hi, input logic [31:0] lo,
                                               input logic [1:0] off, input logic [2:0] op);
    logic [63:0] pair;
    logic [31:0] lane;
    pair = {hi, lo};
    lane = pair[{off, 3'b000} +: 32];
    case (op)
      3'b000:  load_extract = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_extract = {24'b0, lane[7:0]};
      3'b001:  load_extract = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_extract = {16'b0, lane[15:0]};
      default: load_extract = lane;
    endcase
  endfunction

  logic [31:0] mem [NWORDS];
  logic [31:0] rd_word_q;

  state_e state_q, state_d;

  logic [WIDX_W-1:0] req_widx, req_widx1;
  logic [1:0]        req_off;
  logic [7:0]        req_be64;
  logic [63:0]       req_wd64;
  logic              req_misal, req_err, req_split, handshake;

  logic              mem_we, mem_re;
  logic [3:0]        mem_be;
  logic [WIDX_W-1:0] mem_waddr, mem_raddr;
  logic [31:0]       mem_wdata;

  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic              resp_we_q, resp_we_d, resp_split_q, resp_split_d;
  logic [2:0]        resp_op_q, resp_op_d;
  logic [1:0]        resp_off_q, resp_off_d;
  logic [WIDX_W-1:0] sp_widx_q, sp_widx_d;
  logic [3:0]        sp_be_q, sp_be_d;
  logic [31:0]       sp_wdata_q, sp_wdata_d, lo_q, lo_d;

  always_comb begin
    req_widx  = req_addr[ADDR_WIDTH-1:2];
    req_widx1 = req_widx + WIDX_W'(1);
    req_off   = req_addr[1:0];
    req_be64  = {4'b0000, size_mask(req_op)} << req_off;
    req_wd64  = {32'b0, req_wdata} << {req_off, 3'b000};
    req_misal = |req_be64[7:4];
    req_err   = op_illegal(req_we, req_op) | (req_misal & ~MISALIGN_SPLIT);
    req_split = req_misal & ~req_err;
    handshake = req_valid & req_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_ACCEPT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCEPT: if (handshake && req_split) state_d = ST_SPLIT;
      default:   state_d = ST_ACCEPT;
    endcase
  end

  always_comb begin
    req_ready    = rst_n && (state_q == ST_ACCEPT);
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_be       = 4'b0000;
    mem_waddr    = req_widx;
    mem_raddr    = req_widx;
    mem_wdata    = req_wd64[31:0];
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_we_d    = resp_we_q;
    resp_op_d    = resp_op_q;
    resp_off_d   = resp_off_q;
    resp_split_d = resp_split_q;
    sp_widx_d    = sp_widx_q;
    sp_be_d      = sp_be_q;
    sp_wdata_d   = sp_wdata_q;
    lo_d         = lo_q;
    case (state_q)
      ST_ACCEPT: begin
        if (handshake) begin
          resp_err_d   = req_err;
          resp_we_d    = req_we;
          resp_op_d    = req_op;
          resp_off_d   = req_off;
          resp_split_d = req_split;
          if (!req_err) begin
            if (req_we) begin
              mem_we = 1'b1;
              mem_be = req_be64[3:0];
            end else begin
              mem_re = 1'b1;
            end
          end
          if (req_split) begin
            sp_widx_d  = req_widx1;
            sp_be_d    = req_be64[7:4];
            sp_wdata_d = req_wd64[63:32];
          end else begin
            resp_valid_d = 1'b1;
          end
        end
      end
      default: begin
        // Second half; a reset landing here must leave word w+1 untouched.
        mem_waddr    = sp_widx_q;
        mem_raddr    = sp_widx_q;
        mem_wdata    = sp_wdata_q;
        resp_valid_d = 1'b1;
        if (resp_we_q) begin
          mem_we = rst_n;
          mem_be = sp_be_q;
        end else begin
          mem_re = 1'b1;
          lo_d   = rd_word_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    resp_we_q    <= resp_we_d;
    resp_op_q    <= resp_op_d;
    resp_off_q   <= resp_off_d;
    resp_split_q <= resp_split_d;
    sp_widx_q    <= sp_widx_d;
    sp_be_q      <= sp_be_d;
    sp_wdata_q   <= sp_wdata_d;
    lo_q         <= lo_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_re) rd_word_q <= mem[mem_raddr];
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_valid_q & resp_err_q;
  assign resp_rdata = (resp_valid_q && !resp_err_q && !resp_we_q)
                    ? load_extract(rd_word_q, resp_split_q ? lo_q : rd_word_q, resp_off_q, resp_op_q)
                    : 32'b0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: one split-mode and one reject-mode instance share the
// request bus and are checked against a byte-addressed reference memory.
module tb_data_mem_lsu;

  localparam int AW = 15;

  logic          clk, rst_n;
  logic          req_valid, req_we;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          ready_a, resp_valid_a, err_a, ready_b, resp_valid_b, err_b;
  logic [31:0]   rdata_a, rdata_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_a [0:(1<<AW)-1];
  logic [7:0] mem_b [0:(1<<AW)-1];

  logic [31:0] last_rd_a, last_rd_b;
  logic        last_er_a, last_er_b;
  int          last_lat_a;

  data_mem_lsu #(.ADDR_WIDTH(AW), .MISALIGN_SPLIT(1'b1)) dut_split (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_rdata(rdata_a), .resp_err(err_a));

  data_mem_lsu #(.ADDR_WIDTH(AW), .MISALIGN_SPLIT(1'b0)) dut_err (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_rdata(rdata_b), .resp_err(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mget(input bit split_mode, input int a);
    int i = a % (1 << AW);
    return split_mode ? mem_a[i] : mem_b[i];
  endfunction

  task automatic mset(input bit split_mode, input int a, input logic [7:0] v);
    int i = a % (1 << AW);
    if (split_mode) mem_a[i] = v;
    else            mem_b[i] = v;
  endtask

  // Reference: byte-granular memory, access size and extension straight from the op.
  task automatic model_access(input bit split_mode, input logic we, input logic [2:0] op,
                              input logic [AW-1:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er, output int lat);
    int size;
    bit illegal, misal;
    logic [31:0] v;
    size    = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    illegal = we ? !(op inside {3'b000, 3'b001, 3'b010}) : (op inside {3'b011, 3'b110, 3'b111});
    misal   = (int'(addr) % 4 + size) > 4;
    rd = 32'b0;
    er = 1'b0;
    lat = 1;
    if (illegal || (misal && !split_mode)) begin
      er = 1'b1;
      return;
    end
    if (misal) lat = 2;
    if (we) begin
      for (int i = 0; i < size; i++) mset(split_mode, int'(addr) + i, wd[8*i +: 8]);
    end else begin
      v = 32'b0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mget(split_mode, int'(addr) + i);
      if (op == 3'b000) v = {{24{v[7]}}, v[7:0]};
      if (op == 3'b001) v = {{16{v[15]}}, v[15:0]};
      rd = v;
    end
  endtask

  task automatic step(input logic we, input logic [2:0] op, input logic [AW-1:0] addr,
                      input logic [31:0] wd, input string tag);
    logic [31:0] rd_a, rd_b, erd_a, erd_b;
    logic        er_a, er_b, eer_a, eer_b, rdy1_a;
    int          lat_a, lat_b, elat_a, elat_b;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    chk({tag, ".readyA"}, 32'(ready_a), 32'd1);
    chk({tag, ".readyB"}, 32'(ready_b), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rdy1_a = ready_a;
    lat_a = 0; lat_b = 0; rd_a = 32'b0; rd_b = 32'b0; er_a = 1'b0; er_b = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (resp_valid_a && lat_a == 0) begin lat_a = c; rd_a = rdata_a; er_a = err_a; end
      if (resp_valid_b && lat_b == 0) begin lat_b = c; rd_b = rdata_b; er_b = err_b; end
      if (lat_a != 0 && lat_b != 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk({tag, ".pulseA"}, 32'(resp_valid_a), 32'd0);
    chk({tag, ".pulseB"}, 32'(resp_valid_b), 32'd0);
    model_access(1'b1, we, op, addr, wd, erd_a, eer_a, elat_a);
    model_access(1'b0, we, op, addr, wd, erd_b, eer_b, elat_b);
    chk({tag, ".rdataA"}, rd_a, erd_a);
    chk({tag, ".errA"}, 32'(er_a), 32'(eer_a));
    chk({tag, ".latA"}, 32'(lat_a), 32'(elat_a));
    chk({tag, ".splitReadyA"}, 32'(rdy1_a), (elat_a == 2) ? 32'd0 : 32'd1);
    chk({tag, ".rdataB"}, rd_b, erd_b);
    chk({tag, ".errB"}, 32'(er_b), 32'(eer_b));
    chk({tag, ".latB"}, 32'(lat_b), 32'(elat_b));
    last_rd_a = rd_a; last_er_a = er_a; last_lat_a = lat_a;
    last_rd_b = rd_b; last_er_b = er_b;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
    req_addr = '0; req_wdata = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.readyA", 32'(ready_a), 32'd0);
    chk("rst.readyB", 32'(ready_b), 32'd0);
    chk("rst.validA", 32'(resp_valid_a), 32'd0);
    chk("rst.validB", 32'(resp_valid_b), 32'd0);
    chk("rst.rdataA", rdata_a, 32'd0);
    chk("rst.errA", 32'(err_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.readyA", 32'(ready_a), 32'd1);
    chk("rel.readyB", 32'(ready_b), 32'd1);

    for (int i = 0; i < 64; i++) step(1'b1, 3'b010, AW'(i * 4), 32'b0, "zero");
    step(1'b1, 3'b010, 15'h7FFC, 32'b0, "zero_top");

    // Misaligned word over zeroed memory
    step(1'b1, 3'b010, 15'h000E, 32'h11223344, "sw_split");
    chk("sw_split.errB", 32'(last_er_b), 32'd1);
    step(1'b0, 3'b010, 15'h000C, 32'b0, "lw_0c");
    chk("lw_0c.const", last_rd_a, 32'h33440000);
    chk("lw_0c.constB", last_rd_b, 32'h00000000);
    step(1'b0, 3'b010, 15'h0010, 32'b0, "lw_10");
    chk("lw_10.const", last_rd_a, 32'h00001122);
    step(1'b0, 3'b010, 15'h000E, 32'b0, "lw_0e");
    chk("lw_0e.const", last_rd_a, 32'h11223344);
    chk("lw_0e.lat", 32'(last_lat_a), 32'd2);
    chk("lw_0e.errB", 32'(last_er_b), 32'd1);
    chk("lw_0e.rdataB", last_rd_b, 32'd0);

    step(1'b1, 3'b010, 15'h0010, 32'hDEADBEEF, "sw_10");
    step(1'b0, 3'b000, 15'h0013, 32'b0, "lb_13");
    chk("lb_13.const", last_rd_a, 32'hFFFFFFDE);
    step(1'b0, 3'b100, 15'h0013, 32'b0, "lbu_13");
    chk("lbu_13.const", last_rd_a, 32'h000000DE);
    step(1'b0, 3'b101, 15'h0012, 32'b0, "lhu_12");
    chk("lhu_12.const", last_rd_a, 32'h0000DEAD);
    chk("lhu_12.lat", 32'(last_lat_a), 32'd1);

    step(1'b1, 3'b010, 15'h0020, 32'h0, "sw_20");
    step(1'b1, 3'b000, 15'h0021, 32'h123456AB, "sb_21");
    step(1'b1, 3'b001, 15'h0022, 32'h00008001, "sh_22");
    step(1'b0, 3'b010, 15'h0020, 32'b0, "lw_20");
    chk("lw_20.const", last_rd_a, 32'h8001AB00);
    chk("lw_20.constB", last_rd_b, 32'h8001AB00);

    // Half-word straddling the top of memory into word 0
    step(1'b1, 3'b001, 15'h7FFF, 32'h0000BEEF, "sh_top");
    step(1'b0, 3'b101, 15'h7FFF, 32'b0, "lhu_top");
    chk("lhu_top.const", last_rd_a, 32'h0000BEEF);
    step(1'b0, 3'b100, 15'h7FFF, 32'b0, "lbu_top");
    chk("lbu_top.const", last_rd_a, 32'h000000EF);
    step(1'b0, 3'b100, 15'h0000, 32'b0, "lbu_0");
    chk("lbu_0.const", last_rd_a, 32'h000000BE);

    step(1'b0, 3'b010, 15'h0002, 32'b0, "lw_02");
    chk("lw_02.errB", 32'(last_er_b), 32'd1);
    chk("lw_02.rdataB", last_rd_b, 32'd0);
    step(1'b1, 3'b010, 15'h0001, 32'hFFFFFFFF, "sw_01");
    chk("sw_01.errB", 32'(last_er_b), 32'd1);
    step(1'b0, 3'b010, 15'h0000, 32'b0, "lw_00");
    chk("lw_00.unchangedB", last_rd_b, 32'h00000000);
    step(1'b0, 3'b011, 15'h0004, 32'b0, "ld011");
    chk("ld011.errA", 32'(last_er_a), 32'd1);
    chk("ld011.errB", 32'(last_er_b), 32'd1);
    chk("ld011.rdataA", last_rd_a, 32'd0);

    // Reset landing in the second cycle of a split store
    step(1'b1, 3'b010, 15'h000C, 32'b0, "rz_0c");
    step(1'b1, 3'b010, 15'h0010, 32'b0, "rz_10");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010; req_addr = 15'h000E; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rsplit.readyLow", 32'(ready_a), 32'd0);
    chk("rsplit.noRespT1", 32'(resp_valid_a), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rsplit.noRespT2", 32'(resp_valid_a), 32'd0);
    chk("rsplit.readyInRst", 32'(ready_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rsplit.readyAfter", 32'(ready_a), 32'd1);
    chk("rsplit.noRespAfter", 32'(resp_valid_a), 32'd0);
    mset(1'b1, 32'h0E, 8'h44);
    mset(1'b1, 32'h0F, 8'h33);
    step(1'b0, 3'b010, 15'h000C, 32'b0, "rsplit_lw0c");
    chk("rsplit_lw0c.const", last_rd_a, 32'h33440000);
    step(1'b0, 3'b010, 15'h0010, 32'b0, "rsplit_lw10");
    chk("rsplit_lw10.const", last_rd_a, 32'h00000000);

    for (int n = 0; n < 200; n++) begin
      logic [AW-1:0] a;
      logic [2:0]    o;
      logic          w;
      w = 1'($urandom_range(0, 1));
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 15'h7FFC + AW'($urandom_range(0, 3));
      else                           a = AW'($urandom_range(0, 251));
      step(w, o, a, $urandom, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
